pwr_trig: RTL

- Hysteresis threshold detector that consumes the averaged stream from the moving-average stage (data_out/data_out_valid) and declares signal-present/absent events.
- Events are qualified by minimum-duration counters counted in valid samples.
- Per-burst length is reported on release.
- Sits directly downstream of the moving average and feeds the capture/trigger control logic.

---
 rtl/pwr_trig.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/pwr_trig.sv
// pwr_trig -- hysteresis power-threshold detector.
// Consumes the averaged sample stream and declares signal-present / absent
// events. Both transitions need a minimum run of valid samples. The burst
// length is reported when the burst is released.
// Optional feature: define PWR_TRIG_PEAK_EN to add the burst_peak output,
// which reports the largest sample seen during each burst.
module pwr_trig #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 8,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic signed [DATA_WIDTH-1:0] data_in,
    input  logic                         data_in_valid,
    input  logic signed [DATA_WIDTH-1:0] thresh_hi,
    input  logic signed [DATA_WIDTH-1:0] thresh_lo,
    input  logic [CNT_WIDTH-1:0]         min_on_len,
    input  logic [CNT_WIDTH-1:0]         min_off_len,
    output logic                         det_active,
    output logic                         det_rise,
    output logic                         det_fall,
    output logic [LEN_WIDTH-1:0]         burst_len,
    output logic                         burst_len_valid
`ifdef PWR_TRIG_PEAK_EN
    ,
    output logic signed [DATA_WIDTH-1:0] burst_peak
`endif
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        BELOW     = 3'd1,
        ARMING    = 3'd2,
        ACTIVE    = 3'd3,
        RELEASING = 3'd4
    } state_t;

    state_t               state;
    logic [CNT_WIDTH-1:0] on_cnt;
    logic [CNT_WIDTH-1:0] off_cnt;
    logic [LEN_WIDTH-1:0] len_cnt;

    // Qualification counters stop at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] cnt_inc_sat(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // The burst length counter also stops at all-ones.
    function automatic logic [LEN_WIDTH-1:0] len_inc_sat(input logic [LEN_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // This function removes the trailing below-threshold samples from the
    // burst length. A saturated length only means "at least this long", so
    // it is reported unchanged rather than trimmed.
    function automatic logic [LEN_WIDTH-1:0] trim_len(input logic [LEN_WIDTH-1:0] len,
                                                      input logic [CNT_WIDTH-1:0] trail);
        logic [LEN_WIDTH-1:0] t;
        t = LEN_WIDTH'(trail);
        if (&len)
            return len;
        else if (t > len)
            return '0;
        else
            return len - t;
    endfunction

    // A programmed minimum of zero behaves like a minimum of one.
    logic [CNT_WIDTH-1:0] eff_on;
    logic [CNT_WIDTH-1:0] eff_off;
    assign eff_on  = (min_on_len  == '0) ? CNT_WIDTH'(1) : min_on_len;
    assign eff_off = (min_off_len == '0) ? CNT_WIDTH'(1) : min_off_len;

    // The comparisons are strict and signed. thresh_lo <= thresh_hi, so a
    // sample can never be both above and below.
    logic above;
    logic below;
    assign above = data_in > thresh_hi;
    assign below = data_in < thresh_lo;

    // These are the candidate next counter values. They are used only on
    // cycles that consume a sample.
    logic [CNT_WIDTH-1:0] on_next;
    logic [CNT_WIDTH-1:0] off_next;
    logic [LEN_WIDTH-1:0] len_next;
    assign on_next  = cnt_inc_sat(on_cnt);
    assign off_next = cnt_inc_sat(off_cnt);
    assign len_next = len_inc_sat(len_cnt);

    // A sample is consumed only while enabled. When enable drops, it takes
    // priority over any sample strobe in the same cycle.
    logic smp;
    logic in_burst;
    assign smp      = enable && data_in_valid;
    assign in_burst = (state == ACTIVE) || (state == RELEASING);

    // Entering BELOW already counts as one qualifying sample. This covers an
    // effective minimum of 1, where BELOW goes straight to ACTIVE.
    logic                 rise_now;
    logic [CNT_WIDTH-1:0] qual_cnt;
    assign qual_cnt = (state == BELOW) ? CNT_WIDTH'(1) : on_next;
    assign rise_now = smp && above &&
                      (((state == BELOW)  && (eff_on == CNT_WIDTH'(1))) ||
                       ((state == ARMING) && (on_next >= eff_on)));

    // A normal release happens when the trailing below-threshold run
    // reaches its minimum. The >= compare still releases correctly if
    // min_off_len is lowered during a release.
    logic                 done_now;
    logic [CNT_WIDTH-1:0] trail_cnt;
    assign trail_cnt = (state == ACTIVE) ? CNT_WIDTH'(1) : off_next;
    assign done_now  = smp && below &&
                       (((state == ACTIVE)    && (eff_off == CNT_WIDTH'(1))) ||
                        ((state == RELEASING) && (off_next >= eff_off)));

    // Disabling during a burst ends the burst with the length counted so far.
    logic abort_now;
    assign abort_now = !enable && in_burst;

    // Detector FSM: the state, counters and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            on_cnt          <= '0;
            off_cnt         <= '0;
            len_cnt         <= '0;
            det_active      <= 1'b0;
            det_rise        <= 1'b0;
            det_fall        <= 1'b0;
            burst_len       <= '0;
            burst_len_valid <= 1'b0;
        end else begin
            det_rise        <= 1'b0;
            det_fall        <= 1'b0;
            burst_len_valid <= 1'b0;
            if (!enable) begin
                if (abort_now) begin
                    det_fall        <= 1'b1;
                    burst_len_valid <= 1'b1;
                    burst_len       <= trim_len(len_cnt, off_cnt);
                end
                state      <= IDLE;
                on_cnt     <= '0;
                off_cnt    <= '0;
                len_cnt    <= '0;
                det_active <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= BELOW;
                    end
                    BELOW: begin
                        if (rise_now) begin
                            state      <= ACTIVE;
                            det_rise   <= 1'b1;
                            det_active <= 1'b1;
                            len_cnt    <= LEN_WIDTH'(qual_cnt);
                            on_cnt     <= '0;
                            off_cnt    <= '0;
                        end else if (smp && above) begin
                            state  <= ARMING;
                            on_cnt <= CNT_WIDTH'(1);
                        end
                    end
                    ARMING: begin
                        if (rise_now) begin
                            state      <= ACTIVE;
                            det_rise   <= 1'b1;
                            det_active <= 1'b1;
                            len_cnt    <= LEN_WIDTH'(qual_cnt);
                            on_cnt     <= '0;
                            off_cnt    <= '0;
                        end else if (smp && above) begin
                            on_cnt <= on_next;
                        end else if (smp) begin
                            state  <= BELOW;
                            on_cnt <= '0;
                        end
                    end
                    ACTIVE, RELEASING: begin
                        if (done_now) begin
                            state           <= BELOW;
                            det_fall        <= 1'b1;
                            burst_len_valid <= 1'b1;
                            burst_len       <= trim_len(len_next, trail_cnt);
                            det_active      <= 1'b0;
                            len_cnt         <= '0;
                            off_cnt         <= '0;
                        end else if (smp) begin
                            len_cnt <= len_next;
                            if (below) begin
                                state   <= RELEASING;
                                off_cnt <= trail_cnt;
                            end else begin
                                state   <= ACTIVE;
                                off_cnt <= '0;
                            end
                        end
                    end
                    default: begin
                        state      <= IDLE;
                        on_cnt     <= '0;
                        off_cnt    <= '0;
                        len_cnt    <= '0;
                        det_active <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef PWR_TRIG_PEAK_EN
    localparam logic signed [DATA_WIDTH-1:0] PEAK_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    function automatic logic signed [DATA_WIDTH-1:0] max_s(input logic signed [DATA_WIDTH-1:0] a,
                                                          input logic signed [DATA_WIDTH-1:0] b);
        return (b > a) ? b : a;
    endfunction

    logic signed [DATA_WIDTH-1:0] peak_run;
    logic signed [DATA_WIDTH-1:0] peak_upd;
    assign peak_upd = max_s(peak_run, data_in);

    // Running burst maximum: it restarts from the most negative value at
    // each rise, so the rise sample is its first entry. The result is
    // published alongside burst_len.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            peak_run   <= '0;
            burst_peak <= '0;
        end else begin
            if (rise_now)
                peak_run <= max_s(PEAK_MIN, data_in);
            else if (smp && in_burst)
                peak_run <= peak_upd;
            if (done_now)
                burst_peak <= peak_upd;
            else if (abort_now)
                burst_peak <= peak_run;
        end
    end
`endif

endmodule
